// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM for the OTTER program counter.
// Each cycle it decides whether the PC register loads and which next-PC
// source the PC-select mux presents. It handles branches, load wait
// cycles, MRET, illegal-instruction traps and external interrupts.
//
// Ports:
//   CLK, RST       clock; asynchronous active-high reset
//   ir_opcode      instruction bits [6:0]
//   ir_func3       instruction bits [14:12]
//   ir_sys         instruction bits [31:20]
//   br_eq/lt/ltu   branch comparator results
//   intr           external interrupt request (level, asynchronous)
//   mie            mstatus.MIE from the CSR file
//   fetch_en       instruction-memory read enable
//   pc_we          PC register load enable
//   pc_sel         next-PC select (0 PC+4, 1 JALR, 2 branch, 3 JAL, 4 MTVEC, 5 MEPC)
//   int_taken      pulse: CSR saves mepc and clears MIE
//   illegal_trap   pulse: illegal instruction trapped to MTVEC
//   mret_exec      pulse: CSR restores MIE
module pc_sequencer #(
    parameter int unsigned LOAD_WAIT        = 1,
    parameter int unsigned INTR_SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  ir_opcode,
    input  logic [2:0]  ir_func3,
    input  logic [11:0] ir_sys,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        intr,
    input  logic        mie,
    output logic        fetch_en,
    output logic        pc_we,
    output logic [2:0]  pc_sel,
    output logic        int_taken,
    output logic        illegal_trap,
    output logic        mret_exec
);

    localparam int unsigned CNT_W = 3;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] SEL_PC4    = 3'd0;
    localparam logic [2:0] SEL_JALR   = 3'd1;
    localparam logic [2:0] SEL_BRANCH = 3'd2;
    localparam logic [2:0] SEL_JAL    = 3'd3;
    localparam logic [2:0] SEL_MTVEC  = 3'd4;
    localparam logic [2:0] SEL_MEPC   = 3'd5;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    state_t                        state, next_state;
    logic [CNT_W-1:0]              wb_cnt;
    logic [INTR_SYNC_STAGES-1:0]   intr_sync;
    logic                          intr_s;
    logic                          wb_last;
    logic                          br_legal;
    logic                          br_taken;
    state_t                        exit_state;

    // Interrupt request synchronizer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            intr_sync <= '0;
        end else begin
            intr_sync[0] <= intr;
            for (int i = 1; i < int'(INTR_SYNC_STAGES); i++) begin
                intr_sync[i] <= intr_sync[i-1];
            end
        end
    end

    assign intr_s  = intr_sync[INTR_SYNC_STAGES-1];
    assign wb_last = (wb_cnt == CNT_W'(LOAD_WAIT - 1));

    // Where an instruction goes once it retires
    assign exit_state = (intr_s && mie) ? ST_INTR : ST_FETCH;

    // Branch condition decode
    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (ir_func3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Writeback wait counter; idle at zero outside WB
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_cnt <= '0;
        end else if (state == ST_WB && !wb_last) begin
            wb_cnt <= wb_cnt + CNT_W'(1);
        end else begin
            wb_cnt <= '0;
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state   = state;
        fetch_en     = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = SEL_PC4;
        int_taken    = 1'b0;
        illegal_trap = 1'b0;
        mret_exec    = 1'b0;

        case (state)
            ST_FETCH: begin
                fetch_en   = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                pc_we      = 1'b1;
                next_state = exit_state;
                case (ir_opcode)
                    OP_JAL:  pc_sel = SEL_JAL;
                    OP_JALR: pc_sel = SEL_JALR;
                    OP_BRANCH: begin
                        if (br_legal) begin
                            pc_sel = br_taken ? SEL_BRANCH : SEL_PC4;
                        end else begin
                            pc_sel       = SEL_MTVEC;
                            illegal_trap = 1'b1;
                            next_state   = ST_FETCH;
                        end
                    end
                    OP_LOAD: begin
                        pc_we      = 1'b0;
                        next_state = ST_WB;
                    end
                    OP_STORE, OP_OP, OP_IMM, OP_LUI, OP_AUIPC: pc_sel = SEL_PC4;
                    OP_SYSTEM: begin
                        if (ir_func3 == 3'b000 && ir_sys == 12'h302) begin
                            pc_sel    = SEL_MEPC;
                            mret_exec = 1'b1;
                        end else begin
                            pc_sel = SEL_PC4;
                        end
                    end
                    default: begin
                        // Trap wins over a pending interrupt
                        pc_sel       = SEL_MTVEC;
                        illegal_trap = 1'b1;
                        next_state   = ST_FETCH;
                    end
                endcase
            end
            ST_WB: begin
                if (wb_last) begin
                    pc_we      = 1'b1;
                    next_state = exit_state;
                end
            end
            ST_INTR: begin
                pc_sel     = SEL_MTVEC;
                pc_we      = 1'b1;
                int_taken  = 1'b1;
                next_state = ST_FETCH;
            end
            default: next_state = ST_FETCH;
        endcase

        // Outputs drop immediately while reset is held
        if (RST) begin
            fetch_en     = 1'b0;
            pc_we        = 1'b0;
            pc_sel       = SEL_PC4;
            int_taken    = 1'b0;
            illegal_trap = 1'b0;
            mret_exec    = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (LOAD_WAIT=2, INTR_SYNC_STAGES=2).
module tb_pc_sequencer;

    logic        CLK;
    logic        RST;
    logic [6:0]  ir_opcode;
    logic [2:0]  ir_func3;
    logic [11:0] ir_sys;
    logic        br_eq, br_lt, br_ltu;
    logic        intr, mie;
    logic        fetch_en, pc_we;
    logic [2:0]  pc_sel;
    logic        int_taken, illegal_trap, mret_exec;

    int tests_run;
    int tests_failed;

    localparam logic [6:0] OP_ADD    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b0000000;

    pc_sequencer #(
        .LOAD_WAIT        (2),
        .INTR_SYNC_STAGES (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ir_opcode    (ir_opcode),
        .ir_func3     (ir_func3),
        .ir_sys       (ir_sys),
        .br_eq        (br_eq),
        .br_lt        (br_lt),
        .br_ltu       (br_ltu),
        .intr         (intr),
        .mie          (mie),
        .fetch_en     (fetch_en),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .int_taken    (int_taken),
        .illegal_trap (illegal_trap),
        .mret_exec    (mret_exec)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle and settle away from the clock edge
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] sys);
        ir_opcode = op;
        ir_func3  = f3;
        ir_sys    = sys;
    endtask

    // Packed view of all outputs: {fetch_en, pc_we, pc_sel, int_taken, illegal_trap, mret_exec}
    function automatic logic [11:0] outs(input logic f, input logic w, input logic [2:0] s,
                                         input logic it, input logic il, input logic mr);
        return {4'b0, f, w, s, it, il, mr};
    endfunction

    logic [11:0] obs;
    always_comb obs = outs(fetch_en, pc_we, pc_sel, int_taken, illegal_trap, mret_exec);

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST = 1'b1;
        set_ir(OP_ADD, 3'b000, 12'h000);
        br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        intr = 1'b0; mie = 1'b0;

        step();
        step();
        check("reset_outputs", obs, outs(0, 0, 0, 0, 0, 0));

        // Release reset: FETCH, then ADD in EXEC, repeating every 2 cycles
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("first_fetch", obs, outs(1, 0, 0, 0, 0, 0));
        step();
        check("add_exec", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        check("add_refetch", obs, outs(1, 0, 0, 0, 0, 0));
        step();
        check("add_exec2", obs, outs(0, 1, 0, 0, 0, 0));

        // BNE not equal: taken
        step();
        set_ir(OP_BRANCH, 3'b001, 12'h000);
        br_eq = 1'b0;
        step();
        check("bne_taken", obs, outs(0, 1, 2, 0, 0, 0));
        step();
        check("bne_fetch", obs, outs(1, 0, 0, 0, 0, 0));
        br_eq = 1'b1;
        step();
        check("bne_not_taken", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        set_ir(OP_BRANCH, 3'b100, 12'h000);
        br_lt = 1'b1;
        step();
        check("blt_taken", obs, outs(0, 1, 2, 0, 0, 0));
        step();
        set_ir(OP_BRANCH, 3'b110, 12'h000);
        br_ltu = 1'b0;
        step();
        check("bltu_not_taken", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        set_ir(OP_BRANCH, 3'b010, 12'h000);
        step();
        check("branch_illegal_f3", obs, outs(0, 1, 4, 0, 1, 0));
        step();
        check("after_trap_fetch", obs, outs(1, 0, 0, 0, 0, 0));
        br_eq = 1'b0; br_lt = 1'b0;

        // Jumps and an unknown opcode
        set_ir(OP_JAL, 3'b000, 12'h000);
        step();
        check("jal", obs, outs(0, 1, 3, 0, 0, 0));
        step();
        set_ir(OP_JALR, 3'b000, 12'h000);
        step();
        check("jalr", obs, outs(0, 1, 1, 0, 0, 0));
        step();
        set_ir(OP_BAD, 3'b000, 12'h000);
        step();
        check("illegal_opcode", obs, outs(0, 1, 4, 0, 1, 0));

        // LOAD with two writeback cycles: 4 cycles total
        step();
        set_ir(OP_LOAD, 3'b010, 12'h000);
        step();
        check("load_exec", obs, outs(0, 0, 0, 0, 0, 0));
        step();
        check("load_wb1", obs, outs(0, 0, 0, 0, 0, 0));
        step();
        check("load_wb2", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        check("load_then_fetch", obs, outs(1, 0, 0, 0, 0, 0));

        // Interrupt during ADD: two sync stages delay it by one instruction
        set_ir(OP_ADD, 3'b000, 12'h000);
        intr = 1'b1; mie = 1'b1;
        step();
        check("intr_sync_exec", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        check("intr_sync_fetch", obs, outs(1, 0, 0, 0, 0, 0));
        step();
        check("intr_exec", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        check("intr_entered", obs, outs(0, 1, 4, 1, 0, 0));
        step();
        check("intr_pulse_ends", obs, outs(1, 0, 0, 0, 0, 0));

        // Interrupt masked by mie=0
        mie = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("masked_exec", obs, outs(0, 1, 0, 0, 0, 0));
            step();
            check("masked_no_intr", obs, outs(1, 0, 0, 0, 0, 0));
        end

        // Non-MRET SYSTEM encoding
        set_ir(OP_SYSTEM, 3'b000, 12'h000);
        step();
        check("ecall", obs, outs(0, 1, 0, 0, 0, 0));
        step();

        // MRET with intr held, mie=0 at MRET time
        set_ir(OP_SYSTEM, 3'b000, 12'h302);
        step();
        check("mret", obs, outs(0, 1, 5, 0, 0, 1));
        step();
        check("mret_to_fetch", obs, outs(1, 0, 0, 0, 0, 0));
        mie = 1'b1;
        set_ir(OP_ADD, 3'b000, 12'h000);
        step();
        check("post_mret_exec", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        check("post_mret_intr", obs, outs(0, 1, 4, 1, 0, 0));
        step();
        intr = 1'b0; mie = 1'b0;

        // Reset asserted in the final WB cycle
        set_ir(OP_LOAD, 3'b010, 12'h000);
        step();
        step();
        step();
        check("wb2_before_rst", obs, outs(0, 1, 0, 0, 0, 0));
        #1;
        RST = 1'b1;
        #1;
        check("rst_in_wb_async", obs, outs(0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_restart_fetch", obs, outs(1, 0, 0, 0, 0, 0));

        // A LOAD after the reset still sees a full WB count
        step();
        check("reload_exec", obs, outs(0, 0, 0, 0, 0, 0));
        step();
        check("reload_wb1", obs, outs(0, 0, 0, 0, 0, 0));
        step();
        check("reload_wb2", obs, outs(0, 1, 0, 0, 0, 0));
        step();
        check("reload_fetch", obs, outs(1, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
